bellek_yanitlayici: RTL and testbench

Memory responder for the processor's memory interface: a single-port word RAM at base 0x8000_0000 that answers bellek_adres / bellek_yaz / bellek_yaz_veri / bellek_oku_veri. It also holds a program loader that fills the RAM from a byte stream while keeping the processor in reset. It releases the processor once loading is finished. It flags and counts illegal accesses.

---
 rtl/bellek_yanitlayici.sv | 186 ++++++++++++++++++
 tb/tb_bellek_yanitlayici.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bellek_yanitlayici.sv
// ---------------------------------------------------------------------------
// bellek_yanitlayici
//
// Memory responder for the processor's memory interface. Provides a single
// port word RAM mapped at TABAN_ADRES, plus a program loader that fills the
// RAM from a little-endian byte stream while the processor is held in reset.
// The processor is released once loading has finished. Illegal accesses are
// flagged (sticky) and counted (saturating).
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   bellek_adres     byte address from the processor
//   bellek_oku_veri  combinational read data (0 when out of range)
//   bellek_yaz_veri  processor write data
//   bellek_yaz       processor write strobe (honoured only once running)
//   yukle_gecerli    loader byte valid
//   yukle_bayt       loader byte
//   yukle_son        last byte of the program, qualified by yukle_gecerli
//   yukle_hazir      loader ready (only while loading)
//   islemci_rst      registered reset to the processor
//   hata             sticky error flag
//   hata_sayac       saturating illegal-access count
//
// Optional feature: define BELLEK_YAZ_KORUMA_EN to write-protect the first
// KORUMA_KELIME words against processor writes. Without the macro the whole
// RAM is processor-writable and KORUMA_KELIME has no effect.
// ---------------------------------------------------------------------------
module bellek_yanitlayici #(
    parameter int          DERINLIK      = 1024,
    parameter logic [31:0] TABAN_ADRES   = 32'h8000_0000,
    parameter int          KORUMA_KELIME = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bellek_adres,
    output logic [31:0] bellek_oku_veri,
    input  logic [31:0] bellek_yaz_veri,
    input  logic        bellek_yaz,
    input  logic        yukle_gecerli,
    input  logic [7:0]  yukle_bayt,
    input  logic        yukle_son,
    output logic        yukle_hazir,
    output logic        islemci_rst,
    output logic        hata,
    output logic [15:0] hata_sayac
);

    localparam int          AW    = $clog2(DERINLIK);
    localparam logic [31:0] BOYUT = 32'(4 * DERINLIK);

    typedef enum logic [1:0] {
        YUKLE   = 2'd0,
        TAMAMLA = 2'd1,
        CALIS   = 2'd2
    } durum_t;

    durum_t        r_durum;
    durum_t        w_sonraki;

    logic [31:0]   r_ram [DERINLIK];
    logic [AW:0]   r_isaretci;
    logic [1:0]    r_serit;
    logic [31:0]   r_birlestir;
    logic          r_islemci_rst;
    logic          r_hata;
    logic [15:0]   r_hata_sayac;

    logic [31:0]   w_ofset;
    logic          w_aralikta;
    logic [AW-1:0] w_indeks;
    logic          w_korumali;
    logic          w_aktarim;
    logic [31:0]   w_yeni_kelime;
    logic          w_kelime_tamam;
    logic          w_kismi;
    logic          w_yer_var;
    logic          w_yukleyici_yaz;
    logic          w_tasma;
    logic          w_islemci_istek;
    logic          w_islemci_yaz;
    logic          w_islemci_hata;
    logic          w_hata_olay;

    // Unsigned subtraction makes addresses below the base wrap to huge
    // offsets, so one compare covers both ends of the window.
    assign w_ofset    = bellek_adres - TABAN_ADRES;
    assign w_aralikta = (w_ofset < BOYUT);
    assign w_indeks   = w_ofset[AW+1:2];

`ifdef BELLEK_YAZ_KORUMA_EN
    assign w_korumali = (32'(w_indeks) < 32'(KORUMA_KELIME));
`else
    assign w_korumali = 1'b0;
`endif

    assign bellek_oku_veri = w_aralikta ? r_ram[w_indeks] : 32'h0000_0000;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_durum <= YUKLE;
        else     r_durum <= w_sonraki;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_sonraki = r_durum;
        case (r_durum)
            YUKLE:   if (w_aktarim && yukle_son) w_sonraki = TAMAMLA;
            TAMAMLA: w_sonraki = CALIS;
            CALIS:   w_sonraki = CALIS;
            default: w_sonraki = YUKLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        yukle_hazir = (r_durum == YUKLE);
    end

    assign w_aktarim = yukle_gecerli && yukle_hazir;

    // Current byte dropped into its lane of the word being assembled.
    always_comb begin
        w_yeni_kelime = r_birlestir;
        w_yeni_kelime[{r_serit, 3'b000} +: 8] = yukle_bayt;
    end

    assign w_kelime_tamam  = (r_durum == YUKLE) && w_aktarim && (r_serit == 2'd3);
    assign w_kismi         = (r_durum == TAMAMLA) && (r_serit != 2'd0);
    assign w_yer_var       = (r_isaretci < (AW+1)'(DERINLIK));
    assign w_yukleyici_yaz = (w_kelime_tamam || w_kismi) && w_yer_var;
    assign w_tasma         = (w_kelime_tamam || w_kismi) && !w_yer_var;

    assign w_islemci_istek = (r_durum == CALIS) && bellek_yaz;
    assign w_islemci_yaz   = w_islemci_istek && w_aralikta && !w_korumali;
    assign w_islemci_hata  = w_islemci_istek && (!w_aralikta || w_korumali);
    assign w_hata_olay     = w_tasma || w_islemci_hata;

    // RAM write port. Loader and processor writes live in disjoint states;
    // contents survive reset but nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_yukleyici_yaz)
                r_ram[r_isaretci[AW-1:0]] <= w_kelime_tamam ? w_yeni_kelime : r_birlestir;
            else if (w_islemci_yaz)
                r_ram[w_indeks] <= bellek_yaz_veri;
        end
    end

    // Loader bookkeeping, processor reset and error accounting. The pointer
    // parks at DERINLIK on overflow so later words keep counting as errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_isaretci    <= '0;
            r_serit       <= 2'd0;
            r_birlestir   <= 32'h0;
            r_islemci_rst <= 1'b1;
            r_hata        <= 1'b0;
            r_hata_sayac  <= 16'h0;
        end else begin
            r_islemci_rst <= (w_sonraki != CALIS);
            if ((r_durum == YUKLE) && w_aktarim) begin
                if (r_serit == 2'd3) begin
                    r_serit     <= 2'd0;
                    r_birlestir <= 32'h0;
                    if (w_yer_var) r_isaretci <= r_isaretci + 1'b1;
                end else begin
                    r_serit     <= r_serit + 2'd1;
                    r_birlestir <= w_yeni_kelime;
                end
            end else if (r_durum == TAMAMLA) begin
                r_serit     <= 2'd0;
                r_birlestir <= 32'h0;
            end
            if (w_hata_olay) begin
                r_hata <= 1'b1;
                if (r_hata_sayac != 16'hFFFF) r_hata_sayac <= r_hata_sayac + 16'h1;
            end
        end
    end

    assign islemci_rst = r_islemci_rst;
    assign hata        = r_hata;
    assign hata_sayac  = r_hata_sayac;

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// ---------------------------------------------------------------------------
// tb_bellek_yanitlayici
//
// Directed bench for bellek_yanitlayici. A default instance (DERINLIK=1024)
// covers loading, release timing, processor reads/writes and resets; a
// second instance with DERINLIK=4 covers loader overflow. Both share the
// stimulus inputs but have separate resets. Honours BELLEK_YAZ_KORUMA_EN.
// ---------------------------------------------------------------------------
module tb_bellek_yanitlayici;

    logic        clk;
    logic        rst;
    logic        rst4;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_yaz_veri;
    logic        bellek_yaz;
    logic        yukle_gecerli;
    logic [7:0]  yukle_bayt;
    logic        yukle_son;

    logic [31:0] oku_veri,   oku_veri4;
    logic        yukle_hazir, yukle_hazir4;
    logic        islemci_rst, islemci_rst4;
    logic        hata,        hata4;
    logic [15:0] hata_sayac,  hata_sayac4;

    int assertCount = 0;
    int failCount   = 0;

    bellek_yanitlayici dut (
        .clk(clk), .rst(rst),
        .bellek_adres(bellek_adres), .bellek_oku_veri(oku_veri),
        .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz(bellek_yaz),
        .yukle_gecerli(yukle_gecerli), .yukle_bayt(yukle_bayt), .yukle_son(yukle_son),
        .yukle_hazir(yukle_hazir), .islemci_rst(islemci_rst),
        .hata(hata), .hata_sayac(hata_sayac)
    );

    bellek_yanitlayici #(.DERINLIK(4)) dut4 (
        .clk(clk), .rst(rst4),
        .bellek_adres(bellek_adres), .bellek_oku_veri(oku_veri4),
        .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz(bellek_yaz),
        .yukle_gecerli(yukle_gecerli), .yukle_bayt(yukle_bayt), .yukle_son(yukle_son),
        .yukle_hazir(yukle_hazir4), .islemci_rst(islemci_rst4),
        .hata(hata4), .hata_sayac(hata_sayac4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic son);
        yukle_gecerli = 1'b1;
        yukle_bayt    = b;
        yukle_son     = son;
        tick();
        yukle_gecerli = 1'b0;
        yukle_son     = 1'b0;
    endtask

    task automatic cpuWrite(input logic [31:0] a, input logic [31:0] d);
        bellek_adres    = a;
        bellek_yaz_veri = d;
        bellek_yaz      = 1'b1;
        tick();
        bellek_yaz      = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bellek_adres = a;
        #1;
        checkOutput(tag, oku_veri, exp);
    endtask

    task automatic read4Check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bellek_adres = a;
        #1;
        checkOutput(tag, oku_veri4, exp);
    endtask

    logic [7:0] prog [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    logic [7:0] kisa [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        bellek_adres = 32'h8000_0000; bellek_yaz_veri = 32'h0; bellek_yaz = 1'b0;
        yukle_gecerli = 1'b0; yukle_bayt = 8'h0; yukle_son = 1'b0;
        tick(); tick();

        // Reset state
        checkOutput("rst_hazir",  32'(yukle_hazir), 32'd1);
        checkOutput("rst_islrst", 32'(islemci_rst), 32'd1);
        checkOutput("rst_hata",   32'(hata),        32'd0);
        checkOutput("rst_sayac",  32'(hata_sayac),  32'd0);
        rst = 1'b0;

        // Six bytes, then reset mid-load: first word stays, partial is dropped
        for (int i = 0; i < 6; i++) applyStimulus(8'(8'h11 * (i + 1)), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_hazir",  32'(yukle_hazir), 32'd1);
        checkOutput("midrst_islrst", 32'(islemci_rst), 32'd1);
        checkOutput("midrst_sayac",  32'(hata_sayac),  32'd0);
        readCheck("midrst_ram0", 32'h8000_0000, 32'h4433_2211);

        // Eight-byte program: pointer and lane must have restarted at 0
        for (int i = 0; i < 8; i++) applyStimulus(prog[i], (i == 7));
        checkOutput("tam_hazir",  32'(yukle_hazir), 32'd0);
        checkOutput("tam_islrst", 32'(islemci_rst), 32'd1);
        tick();
        checkOutput("calis_islrst", 32'(islemci_rst), 32'd0);
        checkOutput("calis_hata",   32'(hata),        32'd0);
        readCheck("prog_ram0", 32'h8000_0000, 32'h0050_0513);
        readCheck("prog_ram1", 32'h8000_0004, 32'h0010_0593);

        // Processor accesses while running
        cpuWrite(32'h8000_0FFC, 32'h1234_5678);
        readCheck("wr_top", 32'h8000_0FFC, 32'h1234_5678);
        cpuWrite(32'h8000_1000, 32'hFFFF_FFFF);
        checkOutput("oob_hata",  32'(hata),       32'd1);
        checkOutput("oob_sayac", 32'(hata_sayac), 32'd1);
        readCheck("rd_below", 32'h7FFF_FFFC, 32'h0000_0000);
        readCheck("rd_above", 32'h8000_1000, 32'h0000_0000);
        cpuWrite(32'h8000_0000, 32'hDEAD_BEEF);
`ifdef BELLEK_YAZ_KORUMA_EN
        readCheck("prot_ram0", 32'h8000_0000, 32'h0050_0513);
        checkOutput("prot_sayac", 32'(hata_sayac), 32'd2);
`else
        readCheck("wr_ram0", 32'h8000_0000, 32'hDEAD_BEEF);
        checkOutput("wr0_sayac", 32'(hata_sayac), 32'd1);
`endif
        cpuWrite(32'h8000_0400, 32'h0BAD_C0DE);
        readCheck("wr_400", 32'h8000_0400, 32'h0BAD_C0DE);

        // Reset while running restores loader state and clears errors
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("runrst_islrst", 32'(islemci_rst), 32'd1);
        checkOutput("runrst_hata",   32'(hata),        32'd0);
        checkOutput("runrst_sayac",  32'(hata_sayac),  32'd0);

        // Processor writes are ignored while loading, legal or not
        cpuWrite(32'h8000_0400, 32'h1111_1111);
        cpuWrite(32'h8000_1000, 32'h2222_2222);
        checkOutput("yukle_yaz_hata", 32'(hata), 32'd0);
        readCheck("yukle_yaz_ram", 32'h8000_0400, 32'h0BAD_C0DE);

        // Five bytes: trailing partial word padded with zeros
        for (int i = 0; i < 5; i++) applyStimulus(kisa[i], (i == 4));
        tick();
        readCheck("kisa_ram0", 32'h8000_0000, 32'hDDCC_BBAA);
        readCheck("kisa_ram1", 32'h8000_0004, 32'h0000_00EE);
        checkOutput("kisa_hata", 32'(hata), 32'd0);

        // Small RAM overflow: 20 bytes into 4 words, fifth word dropped
        rst4 = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(8'(i), (i == 19));
        tick();
        checkOutput("ovf_hata",   32'(hata4),        32'd1);
        checkOutput("ovf_sayac",  32'(hata_sayac4),  32'd1);
        checkOutput("ovf_islrst", 32'(islemci_rst4), 32'd0);
        read4Check("ovf_ram0", 32'h8000_0000, 32'h0302_0100);
        read4Check("ovf_ram3", 32'h8000_000C, 32'h0F0E_0D0C);
        read4Check("ovf_oob",  32'h8000_0010, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
